// File: rtl/exe_ctrl_pkg.sv
// Shared EX-stage definitions: optype codes, EX control state encoding and classifiers.
package exe_ctrl_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 4;

    localparam int unsigned I_NOP  = 0;
    localparam int unsigned I_ADD  = 1;
    localparam int unsigned I_ADDI = 2;
    localparam int unsigned I_SUB  = 3;
    localparam int unsigned I_LW   = 4;
    localparam int unsigned I_SW   = 5;
    localparam int unsigned I_BEQ  = 6;
    localparam int unsigned I_JAL  = 7;
    localparam int unsigned I_MUL  = 8;
    localparam int unsigned I_MULH = 9;

    typedef enum logic [1:0] {
        EX_IDLE = 2'd0,
        EX_MUL  = 2'd1,
        EX_EXEC = 2'd2
    } ex_state_e;

    function automatic logic is_load(input int unsigned op);
        return op == I_LW;
    endfunction

    function automatic logic is_mul(input int unsigned op);
        return (op == I_MUL) || (op == I_MULH);
    endfunction

endpackage

// File: rtl/exe_hazard_detect.sv
// Load-use hazard compare between the instruction in EX and the one offered by ID.
module exe_hazard_detect
    import exe_ctrl_pkg::*;
#(
    parameter int unsigned OPTYPE_W = 5
) (
    input  logic                id_valid_i,
    input  logic [REG_W-1:0]    id_rs1_i,
    input  logic [REG_W-1:0]    id_rs2_i,
    input  logic                ex_valid_i,
    input  logic [OPTYPE_W-1:0] ex_optype_i,
    input  logic [REG_W-1:0]    ex_rd_i,
    output logic                hazard_o
);

    logic rd_live;
    logic rd_match;

    always_comb begin
        rd_live  = ex_rd_i != '0;
        rd_match = (ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i);
        hazard_o = id_valid_i && ex_valid_i && is_load(32'(ex_optype_i)) && rd_live && rd_match;
    end

endmodule

// File: rtl/exe_ctrl.sv
// Execute-stage sequencer: EX valid bit, multi-cycle MUL hold, load-use stall, branch flush.
// Optional macro EXE_CTRL_PERF_EN adds stall/flush/MUL-cycle performance counters.
module exe_ctrl
    import exe_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT  = 3,
    parameter int unsigned OPTYPE_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    output logic                id_ready,
    input  logic [OPTYPE_W-1:0] id_optype,
    input  logic [REG_W-1:0]    id_rs1,
    input  logic [REG_W-1:0]    id_rs2,
    input  logic [REG_W-1:0]    id_rd,
    input  logic                jmp_en,
    input  logic                mem_ready,
    output logic                ex_valid,
    output logic [OPTYPE_W-1:0] ex_optype,
    output logic [REG_W-1:0]    ex_rd,
    output logic                ex_done,
    output logic                ex_fire,
    output logic                flush,
`ifdef EXE_CTRL_PERF_EN
    output logic                stall,
    output logic [31:0]         perf_stall_cnt,
    output logic [31:0]         perf_flush_cnt,
    output logic [31:0]         perf_mul_cyc
`else
    output logic                stall
`endif
);

    ex_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [OPTYPE_W-1:0]   optype_q, optype_d;
    logic [REG_W-1:0]      rd_q, rd_d;
    logic                  hazard;
    logic                  accept;

    exe_hazard_detect #(
        .OPTYPE_W (OPTYPE_W)
    ) u_hazard (
        .id_valid_i  (id_valid),
        .id_rs1_i    (id_rs1),
        .id_rs2_i    (id_rs2),
        .ex_valid_i  (ex_valid),
        .ex_optype_i (optype_q),
        .ex_rd_i     (rd_q),
        .hazard_o    (hazard)
    );

    assign ex_valid  = state_q != EX_IDLE;
    assign ex_optype = optype_q;
    assign ex_rd     = rd_q;

    // Handshake terms; rst_n gating keeps them quiet while reset is asserted.
    always_comb begin
        ex_done  = rst_n && (state_q == EX_EXEC);
        ex_fire  = ex_done && mem_ready;
        flush    = ex_fire && jmp_en;
        stall    = rst_n && hazard;
        id_ready = rst_n && !hazard && ((state_q == EX_IDLE) || ex_fire);
        accept   = id_valid && id_ready && !flush;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        optype_d = optype_q;
        rd_d     = rd_q;

        case (state_q)
            EX_IDLE: state_d = EX_IDLE;
            EX_MUL: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = EX_EXEC;
                end
            end
            EX_EXEC: begin
                if (ex_fire) begin
                    state_d = EX_IDLE;
                end
            end
            default: state_d = EX_IDLE;
        endcase

        // A new instruction overrides the drain-to-IDLE path in the same cycle.
        if (accept) begin
            optype_d = id_optype;
            rd_d     = id_rd;
            if (is_mul(32'(id_optype)) && (MUL_LAT > 1)) begin
                state_d = EX_MUL;
                cnt_d   = CNT_W'(MUL_LAT - 1);
            end else begin
                state_d = EX_EXEC;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EX_IDLE;
            cnt_q    <= '0;
            optype_q <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            optype_q <= optype_d;
            rd_q     <= rd_d;
        end
    end

`ifdef EXE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q, mul_cyc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            mul_cyc_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_q + 32'(stall);
            flush_cnt_q <= flush_cnt_q + 32'(flush);
            mul_cyc_q   <= mul_cyc_q + 32'(state_q == EX_MUL);
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
    assign perf_mul_cyc   = mul_cyc_q;
`endif

endmodule

// File: tb/tb_exe_ctrl.sv
// Self-checking bench for exe_ctrl: directed scenarios plus randomized traffic against an occupancy model.
module tb_exe_ctrl;
    import exe_ctrl_pkg::*;

    localparam int unsigned MUL_LAT  = 3;
    localparam int unsigned OPTYPE_W = 5;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                id_valid;
    logic                id_ready;
    logic [OPTYPE_W-1:0] id_optype;
    logic [4:0]          id_rs1, id_rs2, id_rd;
    logic                jmp_en, mem_ready;
    logic                ex_valid;
    logic [OPTYPE_W-1:0] ex_optype;
    logic [4:0]          ex_rd;
    logic                ex_done, ex_fire, flush, stall;
`ifdef EXE_CTRL_PERF_EN
    logic [31:0]         perf_stall_cnt, perf_flush_cnt, perf_mul_cyc;
`endif

    exe_ctrl #(
        .MUL_LAT  (MUL_LAT),
        .OPTYPE_W (OPTYPE_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .id_optype (id_optype),
        .id_rs1    (id_rs1),
        .id_rs2    (id_rs2),
        .id_rd     (id_rd),
        .jmp_en    (jmp_en),
        .mem_ready (mem_ready),
        .ex_valid  (ex_valid),
        .ex_optype (ex_optype),
        .ex_rd     (ex_rd),
        .ex_done   (ex_done),
        .ex_fire   (ex_fire),
        .flush     (flush),
`ifdef EXE_CTRL_PERF_EN
        .stall          (stall),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt),
        .perf_mul_cyc   (perf_mul_cyc)
`else
        .stall     (stall)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: what sits in EX and how many cycles remain before its result is ready.
    bit          m_occ;
    int unsigned m_op, m_rd, m_wait;
    longint      m_stall_cnt, m_flush_cnt, m_mul_cyc;

    // Last observed DUT outputs, for the hand-computed checks.
    int o_ready, o_done, o_fire, o_flush, o_stall, o_valid, o_op, o_rd;

    task automatic chk(input string name, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_occ = 0; m_op = 0; m_rd = 0; m_wait = 0;
        m_stall_cnt = 0; m_flush_cnt = 0; m_mul_cyc = 0;
    endtask

    function automatic int unsigned latency_of(input int unsigned op);
        return ((op == I_MUL) || (op == I_MULH)) ? MUL_LAT - 1 : 0;
    endfunction

    task automatic step(input bit v, input int unsigned op, input int unsigned rs1,
                        input int unsigned rs2, input int unsigned rd,
                        input bit j, input bit mr);
        bit e_haz, e_done, e_fire, e_flush, e_ready, e_acc;
        @(negedge clk);
        id_valid  = v;
        id_optype = OPTYPE_W'(op);
        id_rs1    = 5'(rs1);
        id_rs2    = 5'(rs2);
        id_rd     = 5'(rd);
        jmp_en    = j;
        mem_ready = mr;
        #1;
        e_haz   = v && m_occ && (m_op == I_LW) && (m_rd != 0) && (m_rd == rs1 || m_rd == rs2);
        e_done  = m_occ && (m_wait == 0);
        e_fire  = e_done && mr;
        e_flush = e_fire && j;
        e_ready = !e_haz && (!m_occ || e_fire);
        e_acc   = v && e_ready && !e_flush;

        chk("ex_valid", 64'(ex_valid), 64'(m_occ));
        chk("ex_optype", 64'(ex_optype), 64'(m_op));
        chk("ex_rd", 64'(ex_rd), 64'(m_rd));
        chk("ex_done", 64'(ex_done), 64'(e_done));
        chk("ex_fire", 64'(ex_fire), 64'(e_fire));
        chk("flush", 64'(flush), 64'(e_flush));
        chk("stall", 64'(stall), 64'(e_haz));
        chk("id_ready", 64'(id_ready), 64'(e_ready));
`ifdef EXE_CTRL_PERF_EN
        chk("perf_stall_cnt", 64'(perf_stall_cnt), m_stall_cnt & 64'hFFFF_FFFF);
        chk("perf_flush_cnt", 64'(perf_flush_cnt), m_flush_cnt & 64'hFFFF_FFFF);
        chk("perf_mul_cyc", 64'(perf_mul_cyc), m_mul_cyc & 64'hFFFF_FFFF);
`endif
        o_ready = int'(id_ready); o_done = int'(ex_done); o_fire = int'(ex_fire);
        o_flush = int'(flush); o_stall = int'(stall); o_valid = int'(ex_valid);
        o_op = int'(ex_optype); o_rd = int'(ex_rd);

        @(posedge clk);
        m_stall_cnt += longint'(e_haz);
        m_flush_cnt += longint'(e_flush);
        if (m_occ && m_wait > 0) m_mul_cyc++;
        if (e_fire) m_occ = 0;
        else if (m_occ && m_wait > 0) m_wait--;
        if (e_acc) begin
            m_occ  = 1;
            m_op   = op;
            m_rd   = rd;
            m_wait = latency_of(op);
        end
    endtask

    task automatic idle();
        step(0, I_NOP, 0, 0, 0, 0, 1);
    endtask

    int unsigned ops[8] = '{I_ADD, I_ADDI, I_LW, I_SW, I_BEQ, I_MUL, I_MULH, I_SUB};

    initial begin
        rst_n = 0; id_valid = 0; id_optype = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        jmp_en = 0; mem_ready = 1;
        m_reset();
        @(negedge clk); #1;
        chk("rst_ex_valid", 64'(ex_valid), 0);
        chk("rst_id_ready", 64'(id_ready), 0);
        chk("rst_ex_optype", 64'(ex_optype), 0);
        chk("rst_ex_rd", 64'(ex_rd), 0);
        @(negedge clk);
        rst_n = 1;

        // ADD single-cycle and back-to-back.
        step(1, I_ADD, 1, 2, 7, 0, 1);
        chk("add_ready", o_ready, 1);
        step(1, I_ADD, 1, 2, 8, 0, 1);
        chk("add_fire", o_fire, 1);
        chk("add_op", o_op, int'(I_ADD));
        chk("add_rd", o_rd, 7);
        chk("b2b_ready", o_ready, 1);
        idle();
        chk("b2b_fire", o_fire, 1);
        chk("b2b_rd", o_rd, 8);

        // MUL holds EX for MUL_LAT cycles.
        step(1, I_MUL, 1, 2, 3, 0, 1);
        chk("mul_accept", o_ready, 1);
        step(1, I_ADD, 1, 2, 4, 0, 1);
        chk("mul_c1_done", o_done, 0);
        chk("mul_c1_ready", o_ready, 0);
        step(1, I_ADD, 1, 2, 4, 0, 1);
        chk("mul_c2_done", o_done, 0);
        chk("mul_c2_ready", o_ready, 0);
        step(1, I_ADD, 1, 2, 4, 0, 1);
        chk("mul_c3_fire", o_fire, 1);
        chk("mul_c3_ready", o_ready, 1);
        idle();

        // Load-use bubble, and no bubble for LW to x0.
        step(1, I_LW, 2, 0, 5, 0, 1);
        step(1, I_ADD, 5, 1, 6, 0, 1);
        chk("lu_stall", o_stall, 1);
        chk("lu_ready", o_ready, 0);
        chk("lu_fire", o_fire, 1);
        step(1, I_ADD, 5, 1, 6, 0, 1);
        chk("lu_after_stall", o_stall, 0);
        chk("lu_after_ready", o_ready, 1);
        idle();
        step(1, I_LW, 2, 0, 0, 0, 1);
        step(1, I_ADD, 0, 1, 6, 0, 1);
        chk("x0_stall", o_stall, 0);
        chk("x0_ready", o_ready, 1);
        idle();

        // Taken branch flushes the ID instruction; not-taken lets it in.
        step(1, I_BEQ, 1, 2, 0, 0, 1);
        step(1, I_ADDI, 1, 0, 9, 1, 1);
        chk("flush_hi", o_flush, 1);
        idle();
        chk("flush_empty", o_valid, 0);
        step(1, I_BEQ, 1, 2, 0, 0, 1);
        step(1, I_ADDI, 1, 0, 9, 0, 1);
        chk("nt_flush", o_flush, 0);
        idle();
        chk("nt_valid", o_valid, 1);
        chk("nt_rd", o_rd, 9);

        // MEM backpressure holds the result.
        step(1, I_ADD, 1, 2, 10, 0, 1);
        step(1, I_ADD, 1, 2, 11, 0, 0);
        chk("bp_done", o_done, 1);
        chk("bp_fire", o_fire, 0);
        chk("bp_ready", o_ready, 0);
        step(1, I_ADD, 1, 2, 11, 0, 0);
        chk("bp_rd_stable", o_rd, 10);
        step(1, I_ADD, 1, 2, 11, 0, 1);
        chk("bp_release", o_fire, 1);
        idle();

        // Asynchronous reset in the middle of a MUL.
        step(1, I_MUL, 1, 2, 12, 0, 1);
        idle();
        @(negedge clk);
        id_valid = 0;
        #2 rst_n = 0;
        #1;
        chk("rstmul_valid", 64'(ex_valid), 0);
        chk("rstmul_fire", 64'(ex_fire), 0);
        chk("rstmul_done", 64'(ex_done), 0);
        m_reset();
        @(negedge clk);
        rst_n = 1;
        step(1, I_ADD, 1, 2, 13, 0, 1);
        chk("post_rst_ready", o_ready, 1);
        idle();
        chk("post_rst_fire", o_fire, 1);
        chk("post_rst_rd", o_rd, 13);

        // Randomized traffic with small register indices to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(3, 0) != 0, ops[$urandom_range(7, 0)],
                 $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0),
                 $urandom_range(3, 0) == 0, $urandom_range(3, 0) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/exe_ctrl.md
Name: exe_ctrl

Overview:
Execute-stage sequencer for the EX ALU wrapper.
- Owns the EX pipeline register valid bit and accepts decoded instructions from ID with a valid/ready handshake.
- Holds multi-cycle MUL/MULH for a fixed latency, inserts a one-cycle bubble on load-use hazards, and flushes ID on a taken branch or jump.
- Hands completed instructions to MEM under MEM backpressure.

Parameters:
MUL_LAT, 3, cycles an I_MUL/I_MULH occupies EX before completion; legal range 1..15
OPTYPE_W, 5, width of optype field

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID presents an instruction
id_ready  out  1  EX accepts this cycle (combinational)
id_optype  in  OPTYPE_W  decoded optype (`I_* codes)
id_rs1  in  5  source register 1 index
id_rs2  in  5  source register 2 index
id_rd  in  5  destination register index
jmp_en  in  1  branch/jump taken, from the EX ALU wrapper, for the instruction currently in EX
mem_ready  in  1  MEM stage can take the EX result
ex_valid  out  1  EX register holds a live instruction
ex_optype  out  OPTYPE_W  latched optype driving the EX ALU wrapper
ex_rd  out  5  latched destination index
ex_done  out  1  EX result valid this cycle
ex_fire  out  1  ex_done && mem_ready; result transferred to MEM
flush  out  1  ex_fire && jmp_en; kill the ID/IF instruction
stall  out  1  load-use hazard is blocking ID this cycle

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, ex_valid=0, ex_optype=0, ex_rd=0, cnt=0.
  - All combinational outputs forced to 0 while rst_n is low.
  - Reset mid-MUL aborts it with no ex_fire.
- States: IDLE (empty), MUL (counting), EXEC (result ready, waiting for MEM). ex_valid=1 in MUL and EXEC.
- hazard = id_valid && ex_valid && ex_optype==`I_LW && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2).
- id_ready = !hazard && (state==IDLE || ex_fire). stall = hazard.
- accept = id_valid && id_ready && !flush.
  - On accept: latch optype/rd.
  - Next state is MUL with cnt=MUL_LAT-1 if optype is `I_MUL/`I_MULH and MUL_LAT>1; otherwise EXEC.
- MUL: ex_done=0. cnt decrements each cycle; when cnt==1, next state is EXEC. Completion therefore lands in the MUL_LAT-th cycle after accept.
- EXEC: ex_done=1.
  - mem_ready=0: hold; optype/rd stable.
  - mem_ready=1: ex_fire=1; next state is accept ? new instruction : IDLE.
- Non-MUL latency: accept in cycle N, ex_fire in N+1 if mem_ready. Back-to-back issue gives throughput of 1/cycle.
- Flush: flush=ex_fire&&jmp_en.
  - id_ready may be 1 but the ID instruction is dropped; next state is IDLE.
  - jmp_en is ignored when ex_fire=0.
- Load-use: LW in EXEC with a hazard fires; ID is blocked that cycle and accepted next cycle from IDLE. Exactly one bubble, more if mem_ready stalls the LW.
- rd==x0 never raises a hazard. Simultaneous hazard and flush: flush wins; stall is still reported.

Optional Feature:
EXE_CTRL_PERF_EN
- With macro: adds outputs perf_stall_cnt[31:0], perf_flush_cnt[31:0], perf_mul_cyc[31:0].
  - These count cycles with stall=1, flush events, and cycles spent in MUL.
  - Wrap at 2^32; reset to 0.
- Without macro: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Optype codes stay in the shared instruction.vh.
- Add to that header: EX control state encodings (IDLE=2'd0, MUL=2'd1, EXEC=2'd2) and the `I_LW/`I_MUL/`I_MULH classifier macros.
- One natural sub-module: exe_hazard_detect (purely combinational load-use compare producing hazard). The FSM and counter remain in exe_ctrl.

Test Plan:
- ADD, id_valid cycle 0, mem_ready=1 -> id_ready=1 cycle 0, ex_fire=1 cycle 1, ex_optype=`I_ADD, ex_rd latched; back-to-back ADDs fire every cycle.
- MUL with MUL_LAT=3 accepted cycle 0 -> ex_done=0 cycles 1–2, ex_fire cycle 3, id_ready=0 cycles 1–2, id_ready=1 cycle 3.
- LW x5 then ADD x6,x5,x1 -> stall=1 and id_ready=0 in LW's fire cycle; ADD accepted the next cycle. LW x0 followed by the same ADD -> no stall.
- BEQ fires with jmp_en=1 while id_valid=1 (ADDI) -> flush=1, ADDI not captured, ex_valid=0 next cycle. Same BEQ with jmp_en=0 -> ADDI accepted, flush=0.
- ADD in EXEC with mem_ready=0 for 2 cycles -> ex_done=1, ex_fire=0, outputs stable, id_ready=0; ex_fire when mem_ready rises.
- rst_n pulsed low in cycle 2 of a MUL (MUL_LAT=3) -> ex_valid=0 immediately, no ex_fire; ADD issued after reset fires normally one cycle later.
